// File: rtl/regfile_pkg.sv
// ============================================================
// regfile_pkg : shared defaults and helpers for regfile_sb
// Rev 1.0
// ============================================================
`default_nettype none

package regfile_pkg;

  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 3;

  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_sb_if.sv
// ============================================================
// regfile_sb_if : write, scoreboard and read-port bundle for regfile_sb
// Rev 1.0
// ============================================================
`default_nettype none

interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     mark_en;
  logic [ADDR_W-1:0]        mark_addr;
  logic                     flush;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [DEPTH-1:0]         busy_vec;

  modport master (
    output wr_en, wr_addr, wr_data, mark_en, mark_addr, flush, rd_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, mark_en, mark_addr, flush, rd_addr,
    output rd_data, rd_busy, busy_vec
  );

endinterface

`default_nettype wire

// File: rtl/rf_read_port.sv
// ============================================================
// rf_read_port : one read port -- mux, bypass/zero override, busy view
// Rev 1.0
// ============================================================
`default_nettype none

module rf_read_port #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  wire logic [DEPTH-1:0][DATA_W-1:0] regs,
  input  wire logic [DEPTH-1:0]             busy,
  input  wire logic                         wr_en,
  input  wire logic [ADDR_W-1:0]            wr_addr,
  input  wire logic [DATA_W-1:0]            wr_data,
  input  wire logic [ADDR_W-1:0]            rd_addr,
  output logic      [DATA_W-1:0]            rd_data,
  output logic                              rd_busy
);

  logic hit;

  always_comb begin
    hit     = wr_en && (wr_addr == rd_addr);
    rd_data = regs[rd_addr];
    rd_busy = busy[rd_addr];
    if ((BYPASS != 0) && hit) begin
      rd_data = wr_data;
      rd_busy = 1'b0;
    end
    // The hardwired zero wins even over a same-cycle write to r0.
    if ((ZERO_REG != 0) && (rd_addr == '0)) begin
      rd_data = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================
// regfile_sb : parametrised register file with per-register busy scoreboard
// Rev 1.0
// ============================================================
`default_nettype none

module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input wire logic   clk,
  input wire logic   rst_n,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DEPTH-1:0][DATA_W-1:0]  regs;
  logic [DEPTH-1:0]              busy;
  logic [NUM_RD-1:0][DATA_W-1:0] port_data;
  logic                          wr_live;
  logic                          wr_drop;

  // A write presented while reset is held must not leak through the bypass path.
  assign wr_live = bus.wr_en & rst_n;
  assign wr_drop = (ZERO_REG != 0) && (bus.wr_addr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (bus.wr_en && !wr_drop) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (bus.flush || ((ZERO_REG != 0) && (r == 0))) begin
          busy[r] <= 1'b0;
        end else if (bus.mark_en && (bus.mark_addr == ADDR_W'(r))) begin
          busy[r] <= 1'b1;
        end else if (bus.wr_en && (bus.wr_addr == ADDR_W'(r))) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_port
    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_port (
      .regs    (regs),
      .busy    (busy),
      .wr_en   (wr_live),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .rd_addr (bus.rd_addr[i*ADDR_W +: ADDR_W]),
      .rd_data (port_data[i]),
      .rd_busy (bus.rd_busy[i])
    );
  end

  assign bus.rd_data  = port_data;
  assign bus.busy_vec = busy;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================
// tb_regfile_sb : directed test of regfile_sb with and without bypass
// Rev 1.0
// ============================================================
`default_nettype none

module tb_regfile_sb;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       mark_en;
  logic [2:0] mark_addr;
  logic       flush;
  logic [5:0] rd_addr;

  int checks = 0;
  int errors = 0;

  regfile_sb_if #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2)) bus ();
  regfile_sb_if #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2)) bus_nb ();

  assign bus.wr_en        = wr_en;
  assign bus.wr_addr      = wr_addr;
  assign bus.wr_data      = wr_data;
  assign bus.mark_en      = mark_en;
  assign bus.mark_addr    = mark_addr;
  assign bus.flush        = flush;
  assign bus.rd_addr      = rd_addr;
  assign bus_nb.wr_en     = wr_en;
  assign bus_nb.wr_addr   = wr_addr;
  assign bus_nb.wr_data   = wr_data;
  assign bus_nb.mark_en   = mark_en;
  assign bus_nb.mark_addr = mark_addr;
  assign bus_nb.flush     = flush;
  assign bus_nb.rd_addr   = rd_addr;

  regfile_sb #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  regfile_sb #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic me, input logic [2:0] ma, input logic fl,
                       input logic [2:0] ra0, input logic [2:0] ra1);
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    mark_en   = me;
    mark_addr = ma;
    flush     = fl;
    rd_addr   = {ra1, ra0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd3, 3'd5);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data actual=%h expected=%h", bus.rd_data, 16'h0000); end
    checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL reset_rd_busy actual=%b expected=%b", bus.rd_busy, 2'b00); end
    checks++; if (bus.busy_vec !== 8'h00) begin errors++; $display("FAIL reset_busy_vec actual=%h expected=%h", bus.busy_vec, 8'h00); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.rd_data !== 16'h0000) begin errors++; $display("FAIL release_rd_data actual=%h expected=%h", bus.rd_data, 16'h0000); end
    checks++; if (bus_nb.busy_vec !== 8'h00) begin errors++; $display("FAIL release_busy_vec_nb actual=%h expected=%h", bus_nb.busy_vec, 8'h00); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    drive(1'b1, 3'd3, 8'd12, 1'b0, 3'd0, 1'b0, 3'd1, 3'd2);
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd3, 3'd3);
    #1;
    checks++; if (bus.rd_data !== 16'h0C0C) begin errors++; $display("FAIL wr_rd_data actual=%h expected=%h", bus.rd_data, 16'h0C0C); end
    checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL wr_rd_busy actual=%b expected=%b", bus.rd_busy, 2'b00); end
    checks++; if (bus_nb.rd_data !== 16'h0C0C) begin errors++; $display("FAIL wr_rd_data_nb actual=%h expected=%h", bus_nb.rd_data, 16'h0C0C); end
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd3, 3'd4);
    #1;
    checks++; if (bus.rd_data !== 16'h000C) begin errors++; $display("FAIL wr_rd_other actual=%h expected=%h", bus.rd_data, 16'h000C); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    drive(1'b1, 3'd5, 8'h3C, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 1'b0, 3'd0, 3'd0);
    @(negedge clk);
    drive(1'b1, 3'd5, 8'hA5, 1'b0, 3'd0, 1'b0, 3'd5, 3'd6);
    #1;
    checks++; if (bus.rd_data !== 16'h00A5) begin errors++; $display("FAIL bypass_data actual=%h expected=%h", bus.rd_data, 16'h00A5); end
    checks++; if (bus_nb.rd_data !== 16'h003C) begin errors++; $display("FAIL nobypass_data actual=%h expected=%h", bus_nb.rd_data, 16'h003C); end
    checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL bypass_busy actual=%b expected=%b", bus.rd_busy, 2'b00); end
    checks++; if (bus_nb.rd_busy !== 2'b01) begin errors++; $display("FAIL nobypass_busy actual=%b expected=%b", bus_nb.rd_busy, 2'b01); end
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd5, 3'd5);
    #1;
    checks++; if (bus_nb.rd_data !== 16'hA5A5) begin errors++; $display("FAIL bypass_after actual=%h expected=%h", bus_nb.rd_data, 16'hA5A5); end
    checks++; if (bus.busy_vec !== 8'h00) begin errors++; $display("FAIL bypass_busy_clr actual=%h expected=%h", bus.busy_vec, 8'h00); end
  endtask

  task automatic test_zero();
    @(negedge clk);
    drive(1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 1'b0, 3'd0, 3'd3);
    #1;
    checks++; if (bus.rd_data !== 16'h0C00) begin errors++; $display("FAIL zero_bypass actual=%h expected=%h", bus.rd_data, 16'h0C00); end
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
    #1;
    checks++; if (bus.rd_data !== 16'h0000) begin errors++; $display("FAIL zero_read actual=%h expected=%h", bus.rd_data, 16'h0000); end
    checks++; if (bus_nb.rd_data !== 16'h0000) begin errors++; $display("FAIL zero_read_nb actual=%h expected=%h", bus_nb.rd_data, 16'h0000); end
    checks++; if (bus.busy_vec !== 8'h00) begin errors++; $display("FAIL zero_busy actual=%h expected=%h", bus.busy_vec, 8'h00); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0, 3'd3, 3'd2);
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd3, 3'd2);
    #1;
    checks++; if (bus.busy_vec !== 8'h04) begin errors++; $display("FAIL sb_mark_vec actual=%h expected=%h", bus.busy_vec, 8'h04); end
    checks++; if (bus.rd_busy !== 2'b10) begin errors++; $display("FAIL sb_mark_rd_busy actual=%b expected=%b", bus.rd_busy, 2'b10); end
    drive(1'b1, 3'd2, 8'd7, 1'b1, 3'd2, 1'b0, 3'd3, 3'd2);
    #1;
    checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL sb_wm_busy_byp actual=%b expected=%b", bus.rd_busy, 2'b00); end
    checks++; if (bus_nb.rd_busy !== 2'b10) begin errors++; $display("FAIL sb_wm_busy_nb actual=%b expected=%b", bus_nb.rd_busy, 2'b10); end
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd2, 3'd2);
    #1;
    checks++; if (bus.busy_vec !== 8'h04) begin errors++; $display("FAIL sb_mark_wins actual=%h expected=%h", bus.busy_vec, 8'h04); end
    checks++; if (bus.rd_data !== 16'h0707) begin errors++; $display("FAIL sb_data7 actual=%h expected=%h", bus.rd_data, 16'h0707); end
    drive(1'b1, 3'd2, 8'd9, 1'b0, 3'd0, 1'b0, 3'd2, 3'd2);
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd2, 3'd2);
    #1;
    checks++; if (bus_nb.busy_vec !== 8'h00) begin errors++; $display("FAIL sb_write_clr actual=%h expected=%h", bus_nb.busy_vec, 8'h00); end
    checks++; if (bus_nb.rd_data !== 16'h0909) begin errors++; $display("FAIL sb_data9 actual=%h expected=%h", bus_nb.rd_data, 16'h0909); end
    checks++; if (bus_nb.rd_busy !== 2'b00) begin errors++; $display("FAIL sb_rd_busy_clr actual=%b expected=%b", bus_nb.rd_busy, 2'b00); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    drive(1'b1, 3'd1, 8'h11, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
    @(negedge clk);
    drive(1'b1, 3'd6, 8'h66, 1'b1, 3'd1, 1'b0, 3'd0, 3'd0);
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b0, 3'd1, 3'd6);
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd1, 3'd6);
    #1;
    checks++; if (bus.busy_vec !== 8'h42) begin errors++; $display("FAIL flush_pre_vec actual=%h expected=%h", bus.busy_vec, 8'h42); end
    checks++; if (bus.rd_busy !== 2'b11) begin errors++; $display("FAIL flush_pre_rd_busy actual=%b expected=%b", bus.rd_busy, 2'b11); end
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd1, 3'd6);
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd1, 3'd6);
    #1;
    checks++; if (bus.busy_vec !== 8'h00) begin errors++; $display("FAIL flush_vec actual=%h expected=%h", bus.busy_vec, 8'h00); end
    checks++; if (bus.rd_data !== 16'h6611) begin errors++; $display("FAIL flush_data actual=%h expected=%h", bus.rd_data, 16'h6611); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    drive(1'b1, 3'd4, 8'h44, 1'b0, 3'd0, 1'b0, 3'd4, 3'd4);
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd4, 3'd4);
    #1;
    checks++; if (bus.rd_data !== 16'h4444) begin errors++; $display("FAIL midrst_pre actual=%h expected=%h", bus.rd_data, 16'h4444); end
    @(negedge clk);
    drive(1'b1, 3'd4, 8'h99, 1'b1, 3'd4, 1'b0, 3'd4, 3'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rd_data !== 16'h0000) begin errors++; $display("FAIL midrst_now actual=%h expected=%h", bus.rd_data, 16'h0000); end
    checks++; if (bus_nb.rd_data !== 16'h0000) begin errors++; $display("FAIL midrst_now_nb actual=%h expected=%h", bus_nb.rd_data, 16'h0000); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd4, 3'd1);
    #1;
    checks++; if (bus.rd_data !== 16'h0000) begin errors++; $display("FAIL midrst_after actual=%h expected=%h", bus.rd_data, 16'h0000); end
    checks++; if (bus.busy_vec !== 8'h00) begin errors++; $display("FAIL midrst_busy actual=%h expected=%h", bus.busy_vec, 8'h00); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero();
    test_scoreboard();
    test_flush();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
